// File: rtl/pu_fifo_pkg.sv
// Shared types and helpers for the multi-channel PU FIFO.
// Width helpers size channel selects, occupancy counts and ring pointers;
// pu_ptr_inc advances a ring pointer with wrap at an arbitrary depth.
package pu_fifo_pkg;

    // Entry layout at the default widths; wider builds use the same
    // {data, attr} ordering with their own field widths.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  attr;
    } pu_entry_t;

    // Channel-select width, never narrower than one bit.
    function automatic int pu_cw(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Occupancy width, able to hold 0..depth inclusive.
    function automatic int pu_nw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Ring pointer width, able to hold 0..depth-1.
    function automatic int pu_pw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Advance a ring pointer; depth need not be a power of two.
    function automatic int unsigned pu_ptr_inc(input int unsigned ptr,
                                               input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/pu_fifo_mc_chan.sv
// Single-channel ring buffer: storage, read/write pointers and occupancy.
// push/pop are raw requests for this channel; refusal (full without a
// same-cycle pop, or empty) is decided here. The head entry is presented
// combinationally on rd_data for the parent's output register.
module pu_fifo_mc_chan
    import pu_fifo_pkg::*;
#(
    parameter int EW        = 36,
    parameter int FIFO_SIZE = 3,
    parameter int NW        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] wr_data,
    output logic [EW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [NW-1:0] cnt
);

    localparam int PW = pu_pw(FIFO_SIZE);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] mem [FIFO_SIZE];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == NW'(FIFO_SIZE));
    assign empty   = (cnt == '0);
    // A pop frees the slot a same-cycle push needs when full; an empty
    // channel never bypasses, so pop is refused even with a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy update; push and pop together leave cnt as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= PW'(pu_ptr_inc(32'(wr_ptr), FIFO_SIZE));
            if (pop_ok)
                rd_ptr <= PW'(pu_ptr_inc(32'(rd_ptr), FIFO_SIZE));
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + NW'(1);
                2'b01:   cnt <= cnt - NW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pu_fifo_mc.sv
// Multi-channel PU FIFO: CHANNELS independent ring buffers sharing one
// write port and one registered read port per clock.
// Optional feature macro PU_FIFO_MC_ERR_EN adds sticky per-channel
// overflow/underflow flags and the err_clr input; without it refused
// accesses are dropped silently.
module pu_fifo_mc
    import pu_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ATTR_WIDTH = 4,
    parameter  int FIFO_SIZE  = 3,
    parameter  int CHANNELS   = 2,
    localparam int CW         = pu_cw(CHANNELS),
    localparam int NW         = pu_nw(FIFO_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [ATTR_WIDTH-1:0]  attr_in,
    input  logic [CW-1:0]          wr_ch,
    input  logic                   signal_wr,
    input  logic [CW-1:0]          rd_ch,
    input  logic                   signal_oe,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [ATTR_WIDTH-1:0]  attr_out,
    output logic                   out_valid,
    output logic [CW-1:0]          out_ch,
    output logic [CHANNELS-1:0]    full,
    output logic [CHANNELS-1:0]    empty,
    output logic [CHANNELS*NW-1:0] count
`ifdef PU_FIFO_MC_ERR_EN
    ,
    output logic [CHANNELS-1:0]    overflow,
    output logic [CHANNELS-1:0]    underflow,
    input  logic                   err_clr
`endif
);

    localparam int EW = DATA_WIDTH + ATTR_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ATTR_WIDTH-1:0] attr;
    } entry_t;

    logic                wr_in_range;
    logic                rd_in_range;
    logic [CHANNELS-1:0] push_req;
    logic [CHANNELS-1:0] pop_req;
    logic [CHANNELS-1:0] pop_ok;
    logic [EW-1:0]       rd_data [CHANNELS];
    entry_t              pop_entry;

    // Indices beyond the last channel are ignored outright.
    assign wr_in_range = (32'(wr_ch) < CHANNELS);
    assign rd_in_range = (32'(rd_ch) < CHANNELS);
    assign pop_ok      = pop_req & ~empty;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign push_req[i] = signal_wr && wr_in_range && (wr_ch == CW'(i));
        assign pop_req[i]  = signal_oe && rd_in_range && (rd_ch == CW'(i));

        pu_fifo_mc_chan #(
            .EW        (EW),
            .FIFO_SIZE (FIFO_SIZE),
            .NW        (NW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .push    (push_req[i]),
            .pop     (pop_req[i]),
            .wr_data ({data_in, attr_in}),
            .rd_data (rd_data[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .cnt     (count[i*NW +: NW])
        );
    end

    // Select the head entry of the channel being popped (at most one).
    always_comb begin
        pop_entry = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pop_ok[i])
                pop_entry = rd_data[i];
        end
    end

    // Output register: load on an accepted pop, otherwise hold with valid low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            attr_out  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (|pop_ok) begin
            data_out  <= pop_entry.data;
            attr_out  <= pop_entry.attr;
            out_ch    <= rd_ch;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef PU_FIFO_MC_ERR_EN
    // Sticky error flags; clearing wins over a same-cycle refusal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= '0;
            underflow <= '0;
        end else if (err_clr) begin
            overflow  <= '0;
            underflow <= '0;
        end else begin
            overflow  <= overflow  | (push_req & full & ~pop_ok);
            underflow <= underflow | (pop_req & empty);
        end
    end
`endif

endmodule

// File: tb/tb_pu_fifo_mc.sv
// Self-checking bench for pu_fifo_mc at default parameters (2 channels,
// depth 3). A queue-per-channel reference model tracks expected contents,
// output register and (when PU_FIFO_MC_ERR_EN is defined) sticky flags.
module tb_pu_fifo_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [3:0]  attr_in;
    logic [0:0]  wr_ch;
    logic        signal_wr;
    logic [0:0]  rd_ch;
    logic        signal_oe;
    logic [31:0] data_out;
    logic [3:0]  attr_out;
    logic        out_valid;
    logic [0:0]  out_ch;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic [3:0]  count;
`ifdef PU_FIFO_MC_ERR_EN
    logic [1:0]  overflow;
    logic [1:0]  underflow;
    logic        err_clr;
    logic [1:0]  e_ov;
    logic [1:0]  e_ud;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [35:0] mq [2][$];
    logic [31:0] e_data;
    logic [3:0]  e_attr;
    logic        e_valid;
    logic [0:0]  e_ch;

    always #5 clk = ~clk;

    pu_fifo_mc dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .attr_in   (attr_in),
        .wr_ch     (wr_ch),
        .signal_wr (signal_wr),
        .rd_ch     (rd_ch),
        .signal_oe (signal_oe),
        .data_out  (data_out),
        .attr_out  (attr_out),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .full      (full),
        .empty     (empty),
        .count     (count)
`ifdef PU_FIFO_MC_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow),
        .err_clr   (err_clr)
`endif
    );

    function automatic logic [3:0] m_count();
        return {2'(mq[1].size()), 2'(mq[0].size())};
    endfunction

    function automatic logic [1:0] m_empty();
        return {mq[1].size() == 0, mq[0].size() == 0};
    endfunction

    function automatic logic [1:0] m_full();
        return {mq[1].size() == 3, mq[0].size() == 3};
    endfunction

    task automatic m_reset();
        mq[0].delete();
        mq[1].delete();
        e_data  = '0;
        e_attr  = '0;
        e_valid = 1'b0;
        e_ch    = '0;
`ifdef PU_FIFO_MC_ERR_EN
        e_ov = '0;
        e_ud = '0;
`endif
    endtask

    // Drive one clock of stimulus, advance the model, return at edge + 1.
    task automatic step(input logic wr, input int wch, input logic [31:0] d,
                        input logic [3:0] a, input logic oe, input int rch,
                        input logic clr);
        logic        rd_ok;
        logic        wr_ok;
        logic [35:0] ent;
        signal_wr = wr;
        wr_ch     = 1'(wch);
        data_in   = d;
        attr_in   = a;
        signal_oe = oe;
        rd_ch     = 1'(rch);
`ifdef PU_FIFO_MC_ERR_EN
        err_clr = clr;
`endif
        @(posedge clk);
        rd_ok = oe && (mq[rch].size() != 0);
        wr_ok = wr && ((mq[wch].size() < 3) || (rd_ok && rch == wch));
        if (rd_ok) begin
            ent     = mq[rch].pop_front();
            e_data  = ent[35:4];
            e_attr  = ent[3:0];
            e_valid = 1'b1;
            e_ch    = 1'(rch);
        end else begin
            e_valid = 1'b0;
        end
        if (wr_ok)
            mq[wch].push_back({d, a});
`ifdef PU_FIFO_MC_ERR_EN
        if (clr) begin
            e_ov = '0;
            e_ud = '0;
        end else begin
            if (wr && !wr_ok) e_ov[wch] = 1'b1;
            if (oe && !rd_ok) e_ud[rch] = 1'b1;
        end
`else
        if (clr) ent = '0;
`endif
        #1;
        signal_wr = 1'b0;
        signal_oe = 1'b0;
`ifdef PU_FIFO_MC_ERR_EN
        err_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        m_reset();
        n_cmp++; if (count !== 4'd0)    begin n_bad++; $display("FAIL reset_count got %0h want 0", count); end
        n_cmp++; if (empty !== 2'b11)   begin n_bad++; $display("FAIL reset_empty got %0b want 11", empty); end
        n_cmp++; if (full !== 2'b00)    begin n_bad++; $display("FAIL reset_full got %0b want 00", full); end
        n_cmp++; if (out_valid !== 1'b0 || data_out !== 32'd0 || attr_out !== 4'd0 || out_ch !== 1'b0)
            begin n_bad++; $display("FAIL reset_out got v%0b d%0h a%0h c%0h want all 0", out_valid, data_out, attr_out, out_ch); end
`ifdef PU_FIFO_MC_ERR_EN
        n_cmp++; if (overflow !== 2'b00 || underflow !== 2'b00)
            begin n_bad++; $display("FAIL reset_flags got %0b/%0b want 0/0", overflow, underflow); end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        step(1, 0, 32'd11, 4'd3, 0, 0, 0);
        n_cmp++; if (count[1:0] !== 2'd1) begin n_bad++; $display("FAIL basic_count got %0d want 1", count[1:0]); end
        step(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0b want 1", out_valid); end
        n_cmp++; if (data_out !== 32'd11 || attr_out !== 4'd3)
            begin n_bad++; $display("FAIL basic_data got %0d/%0d want 11/3", data_out, attr_out); end
        n_cmp++; if (out_ch !== 1'b0 || empty[0] !== 1'b1)
            begin n_bad++; $display("FAIL basic_ch_empty got %0b/%0b want 0/1", out_ch, empty[0]); end
    endtask

    task automatic test_full_overflow();
        for (int v = 12; v <= 14; v++) step(1, 1, 32'(v), 4'(v), 0, 0, 0);
        step(1, 1, 32'd15, 4'd15, 0, 0, 0);
        n_cmp++; if (full[1] !== 1'b1 || count[3:2] !== 2'd3)
            begin n_bad++; $display("FAIL ovf_full got full%0b cnt%0d want 1/3", full[1], count[3:2]); end
`ifdef PU_FIFO_MC_ERR_EN
        n_cmp++; if (overflow !== 2'b10) begin n_bad++; $display("FAIL ovf_flag got %0b want 10", overflow); end
`endif
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1, 1, 0);
            n_cmp++; if (data_out !== 32'(12 + k) || out_ch !== 1'b1)
                begin n_bad++; $display("FAIL ovf_pop%0d got %0d ch%0d want %0d ch1", k, data_out, out_ch, 12 + k); end
        end
        n_cmp++; if (empty[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_drop got empty%0b want 1", empty[1]); end
`ifdef PU_FIFO_MC_ERR_EN
        step(0, 0, 0, 0, 0, 0, 1);
        n_cmp++; if (overflow !== 2'b00) begin n_bad++; $display("FAIL ovf_clr got %0b want 00", overflow); end
`endif
    endtask

    task automatic test_wrap();
        for (int v = 1; v <= 3; v++) step(1, 0, 32'(v), 4'(v), 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 32'd4, 4'd4, 0, 0, 0);
        step(1, 0, 32'd5, 4'd5, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            n_cmp++; if (data_out !== 32'(3 + k) || attr_out !== 4'(3 + k))
                begin n_bad++; $display("FAIL wrap_pop%0d got %0d want %0d", k, data_out, 3 + k); end
        end
        n_cmp++; if (count[1:0] !== 2'd0) begin n_bad++; $display("FAIL wrap_count got %0d want 0", count[1:0]); end
    endtask

    task automatic test_full_rw();
        for (int v = 12; v <= 14; v++) step(1, 1, 32'(v), 4'(v), 0, 0, 0);
        step(1, 1, 32'd20, 4'd4, 1, 1, 0);
        n_cmp++; if (data_out !== 32'd12 || count[3:2] !== 2'd3 || full[1] !== 1'b1)
            begin n_bad++; $display("FAIL fullrw got d%0d cnt%0d f%0b want 12/3/1", data_out, count[3:2], full[1]); end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1, 1, 0);
            n_cmp++; if (data_out !== ((k == 2) ? 32'd20 : 32'(13 + k)))
                begin n_bad++; $display("FAIL fullrw_pop%0d got %0d want %0d", k, data_out, (k == 2) ? 20 : 13 + k); end
        end
    endtask

    task automatic test_interleave();
        step(1, 0, 32'hA5A5_0001, 4'hA, 0, 0, 0);
        step(1, 1, 32'hB0B0_0002, 4'hB, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        n_cmp++; if (data_out !== 32'hB0B0_0002 || out_ch !== 1'b1)
            begin n_bad++; $display("FAIL ilv_b got %0h ch%0d want b0b00002 ch1", data_out, out_ch); end
        step(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (data_out !== 32'hA5A5_0001 || out_ch !== 1'b0 || attr_out !== 4'hA)
            begin n_bad++; $display("FAIL ilv_a got %0h ch%0d want a5a50001 ch0", data_out, out_ch); end
        step(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (out_valid !== 1'b0 || data_out !== 32'hA5A5_0001 || out_ch !== 1'b0)
            begin n_bad++; $display("FAIL ilv_under got v%0b %0h want 0 a5a50001", out_valid, data_out); end
`ifdef PU_FIFO_MC_ERR_EN
        n_cmp++; if (underflow !== 2'b01) begin n_bad++; $display("FAIL ilv_uflag got %0b want 01", underflow); end
        step(0, 0, 0, 0, 0, 0, 1);
        n_cmp++; if (underflow !== 2'b00 || overflow !== 2'b00)
            begin n_bad++; $display("FAIL ilv_clr got %0b/%0b want 00/00", underflow, overflow); end
`endif
    endtask

    task automatic test_empty_rw();
        step(1, 0, 32'h77, 4'h7, 1, 0, 0);
        n_cmp++; if (out_valid !== 1'b0 || count[1:0] !== 2'd1)
            begin n_bad++; $display("FAIL emptyrw got v%0b cnt%0d want 0/1", out_valid, count[1:0]); end
        step(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h77)
            begin n_bad++; $display("FAIL emptyrw_pop got v%0b %0h want 1/77", out_valid, data_out); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic wr, oe;
            wr = (n < 200) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
            oe = (n < 200) ? ($urandom_range(1, 0) != 0) : ($urandom_range(3, 0) != 0);
            step(wr, int'($urandom_range(1, 0)), $urandom, 4'($urandom), oe,
                 int'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0));
            n_cmp++; if (out_valid !== e_valid || out_ch !== e_ch)
                begin n_bad++; $display("FAIL rnd_ctl@%0d got v%0b c%0d want v%0b c%0d", n, out_valid, out_ch, e_valid, e_ch); end
            n_cmp++; if (data_out !== e_data || attr_out !== e_attr)
                begin n_bad++; $display("FAIL rnd_data@%0d got %0h/%0h want %0h/%0h", n, data_out, attr_out, e_data, e_attr); end
            n_cmp++; if (count !== m_count() || full !== m_full() || empty !== m_empty())
                begin n_bad++; $display("FAIL rnd_stat@%0d got %0h/%0b/%0b want %0h/%0b/%0b", n, count, full, empty, m_count(), m_full(), m_empty()); end
`ifdef PU_FIFO_MC_ERR_EN
            n_cmp++; if (overflow !== e_ov || underflow !== e_ud)
                begin n_bad++; $display("FAIL rnd_flags@%0d got %0b/%0b want %0b/%0b", n, overflow, underflow, e_ov, e_ud); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 32'h1234, 4'h1, 0, 0, 0);
        step(1, 1, 32'h5678, 4'h2, 0, 0, 0);
        step(1, 1, 32'h9ABC, 4'h3, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        n_cmp++; if (count !== 4'd0 || empty !== 2'b11 || full !== 2'b00)
            begin n_bad++; $display("FAIL midrst_stat got %0h/%0b/%0b want 0/11/00", count, empty, full); end
        n_cmp++; if (data_out !== 32'd0 || out_valid !== 1'b0 || attr_out !== 4'd0)
            begin n_bad++; $display("FAIL midrst_out got %0h v%0b want 0 v0", data_out, out_valid); end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1, 1, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_pop got v%0b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        signal_wr = 1'b0;
        signal_oe = 1'b0;
        wr_ch     = '0;
        rd_ch     = '0;
        data_in   = '0;
        attr_in   = '0;
`ifdef PU_FIFO_MC_ERR_EN
        err_clr = 1'b0;
`endif
        test_reset();
        test_basic();
        test_full_overflow();
        test_wrap();
        test_full_rw();
        test_interleave();
        test_empty_rw();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
